cordic_issue_scheduler: RTL

// - Shares one free-running CORDIC + gain-scaling pipeline between NUM_REQ requesters.
//   The pipeline has no valid and no stall; it only carries a value and an ID tag.
// - Arbitrates round-robin, issuing at most one operand per cycle, and tags each

---
 rtl/cordic_pkg.sv | 35 +++
 rtl/cordic_issue_scheduler_chk.sv | 25 ++
 rtl/cordic_result_fifo.sv | 67 ++++++
 rtl/cordic_issue_scheduler.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and helpers for the CORDIC issue scheduler: tag layout and round-robin pick.
package cordic_pkg;

  localparam int PKG_NUM_REQ  = 4;
  localparam int PKG_ID_WIDTH = 8;
  localparam int REQ_W        = $clog2(PKG_NUM_REQ);
  localparam int SEQ_W        = PKG_ID_WIDTH - REQ_W;

  typedef struct packed {
    logic [REQ_W-1:0] req;
    logic [SEQ_W-1:0] seq;
  } cordic_tag_t;

  typedef struct packed {
    logic             found;
    logic [REQ_W-1:0] idx;
  } rr_pick_t;

  // Walk offsets from the far end so the closest eligible index to ptr is written last.
  function automatic rr_pick_t rr_pick(input logic [PKG_NUM_REQ-1:0] valid,
                                       input logic [REQ_W-1:0]       ptr);
    rr_pick_t         pick;
    logic [REQ_W-1:0] cand;
    pick = '0;
    for (int k = PKG_NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + REQ_W'(k);
      if (valid[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cordic_issue_scheduler_chk.sv
// Run-time checks on scheduler invariants: credit ceiling and no push into a full result FIFO.
module cordic_issue_scheduler_chk #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 3,
  parameter int CREDITS = 4
) (
  input logic                            clock,
  input logic                            reset,
  input logic [NUM_REQ-1:0][CNT_W-1:0]   credit,
  input logic [NUM_REQ-1:0]              overflow
);

  // Sample invariants on every active edge outside reset.
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        assert (credit[i] <= CNT_W'(CREDITS))
          else $error("credit of requester %0d above ceiling: %0d", i, credit[i]);
        assert (!overflow[i])
          else $error("push into full result fifo %0d", i);
      end
    end
  end

endmodule

// File: rtl/cordic_result_fifo.sv
// Synchronous first-word-fall-through result FIFO; push and pop may coincide at full or empty.
module cordic_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             not_empty,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + 1'b1;
    end
  endfunction

  assign not_empty = (count_r != '0);
  assign full      = (count_r == CNT_W'(DEPTH));
  assign do_pop_s  = pop && not_empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage array, written without reset.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cordic_issue_scheduler.sv
// Round-robin issue of tagged operands into a shared no-stall datapath, with credit-guarded
// per-requester result FIFOs fed back by tag.
module cordic_issue_scheduler
  import cordic_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 12,
  parameter int ID_WIDTH = 8,
  parameter int LATENCY  = 11,
  parameter int CREDITS  = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [DATA_W-1:0]         dp_in_value,
  output logic [ID_WIDTH-1:0]       dp_in_id,
  input  logic [DATA_W-1:0]         dp_out_value,
  input  logic [ID_WIDTH-1:0]       dp_out_id,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  output logic                      seq_err,
  output logic                      busy
);
  localparam int CNT_W = $clog2(CREDITS + 1);

  logic [NUM_REQ-1:0][CNT_W-1:0] credit_r;
  logic [NUM_REQ-1:0][SEQ_W-1:0] iss_seq_r;
  logic [NUM_REQ-1:0][SEQ_W-1:0] exp_seq_r;
  logic [REQ_W-1:0]              rr_ptr_r;
  logic [LATENCY:0]              valid_line_r;
  logic [NUM_REQ-1:0]            eligible_s;
  logic [NUM_REQ-1:0]            push_s;
  logic [NUM_REQ-1:0]            pop_s;
  logic [NUM_REQ-1:0]            full_s;
  logic [NUM_REQ-1:0]            overflow_s;
  logic                          mismatch_s;
  rr_pick_t                      pick_s;
  cordic_tag_t                   out_tag_s;

  // Requesters with an offer and at least one credit left.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = req_valid[i] && (credit_r[i] != '0);
    end
  end

  assign pick_s = rr_pick(eligible_s, rr_ptr_r);

  // One-hot accept from the round-robin winner; held low while in reset.
  always_comb begin
    req_ready = '0;
    if (pick_s.found && !reset) begin
      req_ready[pick_s.idx] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign out_tag_s  = cordic_tag_t'(dp_out_id);
  assign pop_s      = rsp_valid & rsp_ready;
  assign overflow_s = push_s & full_s & ~pop_s;

  // Route a returning result by tag and compare its sequence against expectation.
  always_comb begin
    push_s     = '0;
    mismatch_s = 1'b0;
    if (valid_line_r[LATENCY]) begin
      push_s[out_tag_s.req] = 1'b1;
      mismatch_s = (out_tag_s.seq != exp_seq_r[out_tag_s.req]);
    end else begin
      push_s     = '0;
      mismatch_s = 1'b0;
    end
  end

  // Issue register, round-robin pointer, issue sequence counters and in-flight valid line.
  always_ff @(posedge clock) begin
    if (reset) begin
      dp_in_value  <= '0;
      dp_in_id     <= '0;
      valid_line_r <= '0;
      rr_ptr_r     <= '0;
      iss_seq_r    <= '0;
    end else begin
      valid_line_r <= {valid_line_r[LATENCY-1:0], pick_s.found};
      if (pick_s.found) begin
        dp_in_value                <= req_data[pick_s.idx*DATA_W +: DATA_W];
        dp_in_id                   <= {pick_s.idx, iss_seq_r[pick_s.idx]};
        iss_seq_r[pick_s.idx]      <= iss_seq_r[pick_s.idx] + 1'b1;
        rr_ptr_r                   <= pick_s.idx + 1'b1;
      end else begin
        dp_in_value <= '0;
        dp_in_id    <= '0;
      end
    end
  end

  // Credits, expected sequences, sticky error and registered busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      credit_r  <= {NUM_REQ{CNT_W'(CREDITS)}};
      exp_seq_r <= '0;
      seq_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({req_ready[i], pop_s[i]})
          2'b10:   credit_r[i] <= credit_r[i] - 1'b1;
          2'b01:   credit_r[i] <= credit_r[i] + 1'b1;
          default: credit_r[i] <= credit_r[i];
        endcase
      end
      if (valid_line_r[LATENCY]) begin
        exp_seq_r[out_tag_s.req] <= exp_seq_r[out_tag_s.req] + 1'b1;
      end
      if (mismatch_s || (|overflow_s)) begin
        seq_err <= 1'b1;
      end
      busy <= (|valid_line_r) || (|rsp_valid);
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
    cordic_result_fifo #(
      .DEPTH(CREDITS),
      .WIDTH(DATA_W)
    ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push_s[gi]),
      .push_data(dp_out_value),
      .pop      (rsp_ready[gi]),
      .pop_data (rsp_data[gi*DATA_W +: DATA_W]),
      .not_empty(rsp_valid[gi]),
      .full     (full_s[gi])
    );
  end

  cordic_issue_scheduler_chk #(
    .NUM_REQ(NUM_REQ),
    .CNT_W  (CNT_W),
    .CREDITS(CREDITS)
  ) u_chk (
    .clock   (clock),
    .reset   (reset),
    .credit  (credit_r),
    .overflow(overflow_s)
  );

endmodule
